// File: rtl/multi_channel_debouncer_if.sv
// Button bus between raw inputs and the debouncer: raw btn_in in;
// level/press/release/repeat per channel plus the shared sample_tick out.
interface multi_channel_debouncer_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_repeat;
  logic            sample_tick;

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release,
    input  btn_repeat, sample_tick
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release,
    output btn_repeat, sample_tick
  );
endinterface

// File: rtl/multi_channel_debouncer.sv
// N-channel button debouncer: 2-FF sync, shared tick divider, stable count,
// press/release pulses and auto-repeat. Ports: clk, rst_n, bus (slave).
module multi_channel_debouncer #(
  parameter int N_CH           = 4,
  parameter int CLK_DIV        = 250000,
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_DELAY   = 100,
  parameter int REPEAT_RATE    = 25,
  parameter int ACTIVE_LOW     = 0
) (
  input logic clk,
  input logic rst_n,
  multi_channel_debouncer_if.slave bus
);

  localparam int DW   = $clog2(CLK_DIV);
  localparam int CW   = $clog2(STABLE_SAMPLES + 1);
  localparam int HMAX = REPEAT_DELAY + REPEAT_RATE;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [N_CH-1:0] POL = {N_CH{ACTIVE_LOW != 0}};

  logic [DW-1:0]   div_q, div_d;
  logic            tick_q;
  logic [N_CH-1:0] s1_q, s2_q, sync;
  logic [N_CH-1:0] lvl_q, lvl_d;
  logic [N_CH-1:0] prs_q, prs_d;
  logic [N_CH-1:0] rel_q, rel_d;
  logic [N_CH-1:0] rpt_q, rpt_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [HW-1:0]   hc_q  [N_CH];
  logic [HW-1:0]   hc_d  [N_CH];
  logic [HW-1:0]   hinc;

  assign div_d = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
  assign sync  = s2_q ^ POL;

  always_comb begin
    lvl_d = lvl_q;
    prs_d = '0;
    rel_d = '0;
    rpt_d = '0;
    hinc  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      hc_d[i]  = hc_q[i];
      if (tick_q) begin
        if (sync[i] != lvl_q[i]) begin
          if (cnt_q[i] == CW'(STABLE_SAMPLES - 1)) begin
            lvl_d[i] = sync[i];
            cnt_d[i] = '0;
            prs_d[i] = sync[i];
            rel_d[i] = ~sync[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
        // hc saturates into a DELAY..DELAY+RATE reload loop, so a
        // long hold never overflows; press/release ticks clear it.
        hinc = hc_q[i] + HW'(1);
        if (!lvl_q[i] || rel_d[i]) begin
          hc_d[i] = '0;
        end else if (hinc == HW'(HMAX)) begin
          hc_d[i]  = HW'(REPEAT_DELAY);
          rpt_d[i] = 1'b1;
        end else begin
          hc_d[i]  = hinc;
          rpt_d[i] = (hinc == HW'(REPEAT_DELAY));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      s1_q   <= POL;
      s2_q   <= POL;
      lvl_q  <= '0;
      prs_q  <= '0;
      rel_q  <= '0;
      rpt_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        hc_q[i]  <= '0;
      end
    end else begin
      div_q  <= div_d;
      tick_q <= (div_d == DW'(CLK_DIV - 1));
      s1_q   <= bus.btn_in;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      prs_q  <= prs_d;
      rel_q  <= rel_d;
      rpt_q  <= rpt_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        hc_q[i]  <= hc_d[i];
      end
    end
  end

  assign bus.btn_level   = lvl_q;
  assign bus.btn_press   = prs_q;
  assign bus.btn_release = rel_q;
  assign bus.btn_repeat  = (REPEAT_RATE != 0) ? rpt_q : '0;
  assign bus.sample_tick = tick_q;

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Bench for multi_channel_debouncer: directed phases plus random button
// activity, compared every cycle against a tick-level behavioural model.
module tb_multi_channel_debouncer;

  localparam int NC = 4;
  localparam int CD = 4;
  localparam int SS = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multi_channel_debouncer_if #(.N_CH(NC)) bus();

  multi_channel_debouncer #(
    .N_CH(NC), .CLK_DIV(CD), .STABLE_SAMPLES(SS),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int e;
  logic [NC-1:0] r1, r2;
  logic [NC-1:0] m_lvl, e_prs, e_rel, e_rpt;
  logic e_tick;
  int m_dis  [NC];
  int m_held [NC];

  int n_prs [NC];
  int n_rel [NC];
  int n_rpt [NC];
  int prs_e [NC];
  int rel_e [NC];

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)",
                  tag, act, exp, e);
  endtask

  task automatic model_reset();
    e = 0;
    r1 = '0;
    r2 = '0;
    m_lvl = '0;
    e_prs = '0;
    e_rel = '0;
    e_rpt = '0;
    e_tick = 1'b0;
    for (int i = 0; i < NC; i++) begin
      m_dis[i] = 0;
      m_held[i] = 0;
    end
  endtask

  // One clock edge of the model; b is the raw input seen at that edge.
  // The level decision uses the input from two edges earlier, and only
  // in edges that follow a tick cycle.
  task automatic model_edge(input logic [NC-1:0] b);
    logic tick_pre;
    logic [NC-1:0] sy;
    logic was;
    e++;
    tick_pre = ((e - 1) % CD == CD - 1);
    sy = r2;
    r2 = r1;
    r1 = b;
    e_tick = (e % CD == CD - 1);
    e_prs = '0;
    e_rel = '0;
    e_rpt = '0;
    if (tick_pre) begin
      for (int i = 0; i < NC; i++) begin
        was = m_lvl[i];
        if (sy[i] != m_lvl[i]) begin
          m_dis[i]++;
          if (m_dis[i] == SS) begin
            m_lvl[i] = sy[i];
            m_dis[i] = 0;
            if (sy[i]) e_prs[i] = 1'b1;
            else e_rel[i] = 1'b1;
          end
        end else begin
          m_dis[i] = 0;
        end
        if (was && !e_rel[i]) begin
          m_held[i]++;
          if (m_held[i] >= RD && (m_held[i] - RD) % RR == 0)
            e_rpt[i] = 1'b1;
        end else begin
          m_held[i] = 0;
        end
      end
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < NC; i++) begin
      n_prs[i] = 0;
      n_rel[i] = 0;
      n_rpt[i] = 0;
      prs_e[i] = -1;
      rel_e[i] = -1;
    end
  endtask

  task automatic step(input logic [NC-1:0] b);
    bus.btn_in = b;
    @(posedge clk);
    #1;
    model_edge(b);
    check("level",   32'(bus.btn_level),   32'(m_lvl));
    check("press",   32'(bus.btn_press),   32'(e_prs));
    check("release", 32'(bus.btn_release), 32'(e_rel));
    check("repeat",  32'(bus.btn_repeat),  32'(e_rpt));
    check("tick",    32'(bus.sample_tick), 32'(e_tick));
    for (int i = 0; i < NC; i++) begin
      if (bus.btn_press[i])   begin n_prs[i]++; prs_e[i] = e; end
      if (bus.btn_release[i]) begin n_rel[i]++; rel_e[i] = e; end
      if (bus.btn_repeat[i])  n_rpt[i]++;
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, 32'({bus.btn_level, bus.btn_press, bus.btn_release,
                    bus.btn_repeat, bus.sample_tick}), 32'd0);
  endtask

  // rst_n changes 1 time unit after a rising edge, well clear of it.
  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("rst_async");
    for (int k = 0; k < ncyc; k++) begin
      bus.btn_in = 4'($urandom);
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    rst_n = 1'b1;
  endtask

  logic [NC-1:0] b;
  int first_tick, second_tick, ticks, guard;

  initial begin
    bus.btn_in = '0;
    model_reset();
    clr_counts();
    @(posedge clk);
    #1;

    // 1: reset, then tick cadence (first tick in the 4th cycle = edge 3)
    do_reset(6);
    first_tick = -1;
    second_tick = -1;
    for (int k = 0; k < 12; k++) begin
      step('0);
      if (bus.sample_tick) begin
        if (first_tick < 0) first_tick = e;
        else if (second_tick < 0) second_tick = e;
      end
    end
    check("first_tick", 32'(first_tick), 32'd3);
    check("tick_period", 32'(second_tick - first_tick), 32'(CD));

    // 2: clean press/release on ch0
    clr_counts();
    for (int k = 0; k < 40; k++) step(4'b0001);
    check("ch0_press_cnt", 32'(n_prs[0]), 32'd1);
    for (int k = 0; k < 40; k++) step(4'b0000);
    check("ch0_release_cnt", 32'(n_rel[0]), 32'd1);

    // 3: bounce on ch1, toggling every 6 clk
    clr_counts();
    b = '0;
    for (int k = 0; k < 200; k++) begin
      if (k % 6 == 0) b[1] = ~b[1];
      step(b);
    end
    check("ch1_bounce_level", 32'(bus.btn_level[1]), 32'd0);
    check("ch1_bounce_pulses", 32'(n_prs[1] + n_rel[1]), 32'd0);
    for (int k = 0; k < 30; k++) step(4'b0010);
    check("ch1_hold_press", 32'(n_prs[1]), 32'd1);
    for (int k = 0; k < 30; k++) step(4'b0000);

    // 4: auto-repeat on ch2 for 15 held ticks
    guard = 0;
    while (!bus.btn_level[2] && guard < 60) begin
      step(4'b0100);
      guard++;
    end
    check("ch2_rise_timeout", 32'(bus.btn_level[2]), 32'd1);
    clr_counts();
    ticks = 0;
    guard = 0;
    while (ticks < 15 && guard < 200) begin
      step(4'b0100);
      if (bus.sample_tick) ticks++;
      guard++;
    end
    step(4'b0100);
    check("ch2_repeat_cnt", 32'(n_rpt[2]), 32'd6);
    guard = 0;
    while (bus.btn_level[2] && guard < 60) begin
      step(4'b0000);
      guard++;
    end
    check("ch2_fall_timeout", 32'(bus.btn_level[2]), 32'd0);
    clr_counts();
    for (int k = 0; k < 40; k++) step(4'b0000);
    check("ch2_no_repeat", 32'(n_rpt[2]), 32'd0);

    // 5: ch0 press and ch3 release qualify on the same tick
    for (int k = 0; k < 30; k++) step(4'b1000);
    clr_counts();
    for (int k = 0; k < 30; k++) step(4'b0001);
    check("sim_press_cnt", 32'(n_prs[0]), 32'd1);
    check("sim_same_cycle", 32'(prs_e[0]), 32'(rel_e[3]));
    check("sim_others", 32'(n_prs[1] + n_prs[2] + n_rel[1] + n_rel[2]),
          32'd0);
    for (int k = 0; k < 30; k++) step(4'b0000);

    // 6: reset one tick short of a flip on ch0
    guard = 0;
    while (m_dis[0] != 2 && guard < 40) begin
      step(4'b0001);
      guard++;
    end
    check("ch0_cnt2_timeout", 32'(m_dis[0]), 32'd2);
    do_reset(1);
    clr_counts();
    for (int k = 0; k < 20; k++) step(4'b0001);
    check("rst_requal_cnt", 32'(n_prs[0]), 32'd1);
    // sync=1 from edge 3; ticks evaluated at edges 4, 8, 12
    check("rst_requal_edge", 32'(prs_e[0]), 32'd12);

    // 7: random slow button activity on all channels
    b = '0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) b[$urandom_range(0, NC - 1)] ^= 1'b1;
      step(b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
